// File: rtl/axilite_uart_tx_master_if.sv
// rtl/axilite_uart_tx_master_if.sv - AXI-lite channel bundle between the TX master and the UART slave port
interface axilite_uart_tx_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axilite_uart_tx_master.sv
// rtl/axilite_uart_tx_master.sv - byte stream to UART AXI-lite TX bridge (poll STAT, write TX)
// Optional CR insertion before LF when UART_TX_CRLF_EN is defined.
module axilite_uart_tx_master #(
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [31:0] UART_BASE_ADDR   = 32'h0,
    parameter int          LOCAL_ADDR_WIDTH = 32,
    parameter int          LOCAL_DATA_WIDTH = 32
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    output logic       busy_o,
    output logic       err_o,
    axilite_uart_tx_master_if.master m_axilite
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LOCAL_ADDR_WIDTH-1:0] STAT_ADDR = LOCAL_ADDR_WIDTH'(UART_BASE_ADDR + 32'h8);
    localparam logic [LOCAL_ADDR_WIDTH-1:0] TX_ADDR   = LOCAL_ADDR_WIDTH'(UART_BASE_ADDR + 32'h4);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B} state_t;

    state_t                      r_state;
    logic [7:0]                  r_mem [FIFO_DEPTH];
    logic [PTR_W:0]              r_wr_ptr;
    logic [PTR_W:0]              r_rd_ptr;
    logic                        r_arvalid;
    logic                        r_rready;
    logic                        r_awvalid;
    logic                        r_wvalid;
    logic                        r_bready;
    logic [LOCAL_ADDR_WIDTH-1:0] r_araddr;
    logic [LOCAL_ADDR_WIDTH-1:0] r_awaddr;
    logic [LOCAL_DATA_WIDTH-1:0] r_wdata;
    logic                        r_err;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_head;
    logic [7:0] w_tx_byte;
    logic       w_pop_head;
    logic       w_aw_ok;
    logic       w_w_ok;
    logic       w_unused_rdata;

    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_push  = s_valid_i && s_ready_o;
    assign w_pop   = (r_state == WR_B) && m_axilite.bvalid && w_pop_head;

`ifdef UART_TX_CRLF_EN
    logic r_cr_done;

    // An LF head is first sent as CR; the head stays put until the LF itself is written.
    assign w_tx_byte  = (w_head == 8'h0A && !r_cr_done) ? 8'h0D : w_head;
    assign w_pop_head = (w_head != 8'h0A) || r_cr_done;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_cr_done <= 1'b0;
        end else if (r_state == WR_B && m_axilite.bvalid) begin
            r_cr_done <= !w_pop_head;
        end
    end
`else
    assign w_tx_byte  = w_head;
    assign w_pop_head = 1'b1;
`endif

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= s_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // A channel counts as done once its valid is low or its handshake completes this cycle.
    assign w_aw_ok = !r_awvalid || m_axilite.awready;
    assign w_w_ok  = !r_wvalid  || m_axilite.wready;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_araddr  <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= STAT_ADDR;
                        r_state   <= RD_AR;
                    end
                end
                RD_AR: begin
                    if (m_axilite.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axilite.rvalid) begin
                        r_rready <= 1'b0;
                        if (m_axilite.rresp != 2'b00) r_err <= 1'b1;
                        // A failed status read is treated like a full TX FIFO.
                        if (m_axilite.rresp != 2'b00 || m_axilite.rdata[3]) begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_AR;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_awaddr  <= TX_ADDR;
                            r_wdata   <= LOCAL_DATA_WIDTH'(w_tx_byte);
                            r_state   <= WR_AWW;
                        end
                    end
                end
                WR_AWW: begin
                    if (r_awvalid && m_axilite.awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_axilite.wready)   r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axilite.bvalid) begin
                        r_bready <= 1'b0;
                        if (m_axilite.bresp != 2'b00) r_err <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axilite.awaddr  = r_awaddr;
    assign m_axilite.awprot  = 3'b000;
    assign m_axilite.awvalid = r_awvalid;
    assign m_axilite.wdata   = r_wdata;
    assign m_axilite.wstrb   = 4'b0001;
    assign m_axilite.wvalid  = r_wvalid;
    assign m_axilite.bready  = r_bready;
    assign m_axilite.araddr  = r_araddr;
    assign m_axilite.arprot  = 3'b000;
    assign m_axilite.arvalid = r_arvalid;
    assign m_axilite.rready  = r_rready;

    assign w_unused_rdata = ^m_axilite.rdata;

    assign s_ready_o = !reset_i && !w_full;
    assign busy_o    = !w_empty || (r_state != IDLE);
    assign err_o     = r_err;
endmodule
